// File: rtl/thermal_tuner_array.sv
// Multi-channel PDM ring-heater driver: per-channel first-order sigma-delta modulators
// with slew-limited ramping toward targets written over a valid/ready config port.
module thermal_tuner_array #(
  parameter int CHANNELS    = 4,
  parameter int BIT_WIDTH   = 8,
  parameter int SLEW_STEP   = 1,
  parameter int SLEW_DIV    = 16,
  parameter int HEATER_INIT = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CW-1:0]        cfg_chan,
  input  logic [BIT_WIDTH-1:0] cfg_code,
  output logic                 cfg_err,
  input  logic                 kill,
  output logic [CHANNELS-1:0]  heater,
  output logic [CHANNELS-1:0]  settled,
  output logic                 tick
);

  localparam int W  = BIT_WIDTH;
  localparam int DW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SLEW_DIV - 1);
  localparam logic [W:0]    STEP     = (W+1)'(SLEW_STEP);
  localparam logic [W-1:0]  INIT     = W'(HEATER_INIT);
  localparam logic [CW:0]   CH_LIM   = (CW+1)'(CHANNELS);

  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_next;
  logic          r_tick;
  logic          r_cfg_err;
  logic          w_accept;

  assign cfg_ready = ~rst;
  assign w_accept  = cfg_valid & cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign tick      = r_tick;

  // r_tick is registered so that it is high exactly while r_cnt == SLEW_DIV-1
  assign w_cnt_next = (r_cnt == DIV_LAST) ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_tick    <= (w_cnt_next == DIV_LAST);
      r_cfg_err <= w_accept & ({1'b0, cfg_chan} >= CH_LIM);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [W-1:0] r_acc;
      logic [W-1:0] r_cur;
      logic [W-1:0] r_tgt;
      logic         r_heater;
      logic         r_settled;
      logic         w_wr;
      logic [W:0]   w_up;
      logic [W:0]   w_dn;
      logic [W:0]   w_sum;
      logic [W-1:0] w_step_up;
      logic [W-1:0] w_step_dn;
      logic [W-1:0] w_cur_next;
      logic [W-1:0] w_tgt_next;

      assign w_wr       = w_accept & ({1'b0, cfg_chan} == (CW+1)'(gi));
      assign w_tgt_next = w_wr ? cfg_code : r_tgt;

      // Differences are one bit wider so the clamp never wraps
      assign w_up      = {1'b0, r_tgt} - {1'b0, r_cur};
      assign w_dn      = {1'b0, r_cur} - {1'b0, r_tgt};
      assign w_step_up = (w_up > STEP) ? STEP[W-1:0] : w_up[W-1:0];
      assign w_step_dn = (w_dn > STEP) ? STEP[W-1:0] : w_dn[W-1:0];

      always_comb begin
        w_cur_next = r_cur;
        if (r_tick) begin
          if (r_tgt > r_cur)      w_cur_next = r_cur + w_step_up;
          else if (r_cur > r_tgt) w_cur_next = r_cur - w_step_dn;
        end
      end

      assign w_sum = {1'b0, r_acc} + {1'b0, r_cur};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc     <= '0;
          r_cur     <= INIT;
          r_tgt     <= INIT;
          r_heater  <= 1'b0;
          r_settled <= 1'b1;
        end else begin
          r_acc     <= w_sum[W-1:0];
          r_heater  <= w_sum[W] & ~kill;
          r_cur     <= w_cur_next;
          r_tgt     <= w_tgt_next;
          r_settled <= (w_cur_next == w_tgt_next);
        end
      end

      assign heater[gi]  = r_heater;
      assign settled[gi] = r_settled;
    end
  endgenerate

endmodule

// File: doc/thermal_tuner_array.md
# thermal_tuner_array

Multi-channel successor to the single-heater PDM thermal tuner. Drives `CHANNELS` ring heaters from one clock, each with a first-order sigma-delta PDM modulator of `BIT_WIDTH` resolution. Adds a valid/ready configuration port, per-channel slew-rate-limited ramping from current to target code, per-channel settled flags, and a global synchronous kill. It sits between the ring-locking controller (upstream, issues heater codes) and the heater pads (downstream).

## Interface
- `CHANNELS`, default 4: number of heater channels, range 1..16.
- `BIT_WIDTH`, default 8: PDM code and accumulator width, range 2..16.
- `SLEW_STEP`, default 1: maximum code change per slew tick, range 1..2^BIT_WIDTH-1.
- `SLEW_DIV`, default 16: clock cycles per slew tick, range 1..65535.
- `HEATER_INIT`, default 0: reset value of every channel's target and current code.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: configuration port can accept a write.
- `cfg_chan` in max(1,$clog2(CHANNELS)): channel index of the write.
- `cfg_code` in BIT_WIDTH: new target code.
- `cfg_err` out 1: one-cycle pulse when an accepted write had `cfg_chan >= CHANNELS`.
- `kill` in 1: force all heaters off.
- `heater` out CHANNELS: PDM heater drive, one bit per channel.
- `settled` out CHANNELS: current code equals target code, per channel.
- `tick` out 1: one-cycle slew-tick strobe, for observation.

## Operation
- Reset, asynchronous: `acc[i]`=0, `cur[i]`=`tgt[i]`=`HEATER_INIT`, `heater`=0, `settled`=all 1, `cfg_err`=0, `tick`=0, and the divider counter is 0. `cfg_ready`=0 while `rst` is high and 1 otherwise.
- Config write: a write is accepted on an edge with `cfg_valid & cfg_ready`.
  - Valid channel: `tgt[cfg_chan]` <= `cfg_code`.
  - Invalid channel: no state changes, and `cfg_err`=1 for the following cycle.
  - There is no backpressure beyond reset.
- Slew divider: the counter runs 0..SLEW_DIV-1 and wraps. `tick`=1 in the cycle where counter==SLEW_DIV-1. With `SLEW_DIV`=1, `tick` is 1 every cycle.
- Slew update, on each edge where `tick`=1, for every channel:
  - If `cur<tgt`: `cur` += min(SLEW_STEP, tgt-cur).
  - If `cur>tgt`: `cur` -= min(SLEW_STEP, cur-tgt).
  - Never overshoots and never wraps. Use a BIT_WIDTH+1 bit difference.
- PDM, every edge, per channel: {carry, `acc`} <= `acc` + `cur` (BIT_WIDTH+1 bit sum). `heater[i]` <= carry & ~`kill`.
  - Code c gives exactly c ones per 2^BIT_WIDTH cycles.
  - Code 0 gives constant 0.
- Kill: while `kill`=1, `heater` registers 0 and `acc`, `cur`, `tgt` keep updating normally. Release resumes the PDM pattern with no phase reset.
- `settled[i]` is registered and equals (`cur[i]`==`tgt[i]`) after each edge.

## Timing
- Simultaneous write and tick on the same channel: the slew step uses the pre-edge `tgt`. The new target is stored at the same edge and is first used at the next tick.
- Writes to the same channel on back-to-back cycles: the last write wins.
- Write latency to `settled` falling: 1 cycle, provided the new target differs from `cur`.
- `cur` change to `heater` effect: the first edge after `cur` updates.
- `kill` assertion to `heater`=0: 1 cycle. Deassertion to resumed output: 1 cycle.
- Reset mid-ramp: all state returns to reset values immediately. The first tick comes SLEW_DIV cycles after reset release.

## Test plan
- Duty accuracy. Setup: W=8, write code 64 to channel 0, wait for `settled[0]`. Required: exactly 64 ones on `heater[0]` in any 256 consecutive cycles. Codes 0 and 255 give 0 ones and 255 ones respectively.
- Ramp. Setup: SLEW_STEP=4, SLEW_DIV=16, write code 10 to channel 1 from `cur`=0. Required: `cur` steps 4, 8, 10 on three successive ticks. `settled[1]` falls 1 cycle after the write and rises at the third tick. Ramp back down to 3 follows 6, 3.
- Invalid channel. Setup: CHANNELS=3, write `cfg_chan`=3. Required: `cfg_err` pulses for 1 cycle, and all `tgt`, `cur`, and `heater` behaviour is unchanged.
- Kill. Setup: kill for 20 cycles with channel 0 at code 128. Required: `heater` is 0 throughout those cycles. After release the pattern continues, and the ones count over 256 cycles measured excluding the kill window is still 128.
- Same-edge write and tick. Setup: write a new target on the tick cycle. Required: the step follows the old target, and the next tick moves toward the new target.
- Reset mid-ramp. Setup: assert `rst` asynchronously between edges during a ramp. Required: `heater`=0, `settled` all 1, `cur`=`HEATER_INIT` immediately. The first post-reset tick arrives SLEW_DIV cycles after release.
